ifu: RTL and testbench

- Instruction fetch unit sitting directly upstream of the IF/ID pipeline register.
- Owns the PC and fetches instructions from instruction memory over a simple req/ack bus.
- Delivers each instruction and its address to IF/ID; issues a NOP bubble whenever no instruction is available.
- Honours pipeline hold from control and redirects the PC on branch/jump from execute.

---
 rtl/ifu.sv | 125 ++++++++++++
 tb/tb_ifu.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack bus and feeds IF/ID.
// Latency: a fetched word reaches inst_o one edge after req && ack (registered outputs).
// Backpressure: hold_en freezes the outputs and parks at most one fetched word in a buffer.
module ifu #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_en,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FULL,
        ST_KILL
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } fetch_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    fetch_t      buf_q, buf_d;
    fetch_t      out_q, out_d;

    logic [31:0] jump_pc;
    logic [31:0] pc_inc;

    assign jump_pc = jump_addr_i & ~32'h3;
    assign pc_inc  = pc_q + 32'd4;

    // KILL keeps presenting the abandoned address until its ack retires it.
    assign ibus_req_o  = (state_q == ST_FETCH) || (state_q == ST_KILL);
    assign ibus_addr_o = (state_q == ST_KILL) ? kill_addr_q : pc_q;
    assign inst_o      = out_q.inst;
    assign inst_addr_o = out_q.addr;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        buf_d       = buf_q;
        out_d       = out_q;
        if (jump_flag_i) begin
            pc_d       = jump_pc;
            out_d.inst = NOP_INST;
            buf_d      = '0;
            case (state_q)
                ST_FETCH: begin
                    if (ibus_ack_i) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d     = ST_KILL;
                        kill_addr_d = pc_q;
                    end
                end
                ST_KILL: state_d = ibus_ack_i ? ST_FETCH : ST_KILL;
                default: state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!hold_en) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (ibus_ack_i) begin
                        pc_d = pc_inc;
                        if (hold_en) begin
                            buf_d.inst = ibus_data_i;
                            buf_d.addr = pc_q;
                            state_d    = ST_FULL;
                        end else begin
                            out_d.inst = ibus_data_i;
                            out_d.addr = pc_q;
                        end
                    end else if (!hold_en) begin
                        out_d.inst = NOP_INST;
                    end
                end
                ST_FULL: begin
                    if (!hold_en) begin
                        out_d   = buf_q;
                        buf_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_KILL: begin
                    if (ibus_ack_i) state_d = ST_FETCH;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_ADDR;
            kill_addr_q <= '0;
            buf_q       <= '0;
            out_q.inst  <= NOP_INST;
            out_q.addr  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            buf_q       <= buf_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios plus random hold/jump/reset/wait-state traffic,
// compared every cycle against a transaction-level reference model.
module tb_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        hold_en;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    ifu #(.RESET_ADDR(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold_en     (hold_en),
        .jump_flag_i (jump_flag_i),
        .jump_addr_i (jump_addr_i),
        .ibus_req_o  (ibus_req_o),
        .ibus_addr_o (ibus_addr_o),
        .ibus_ack_i  (ibus_ack_i),
        .ibus_data_i (ibus_data_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory stimulus knobs
    int wait_cnt  = 0;
    int cur_lat   = 0;
    int lat_cfg   = 0;
    bit lat_rand  = 1'b0;
    bit force_ack = 1'b0;

    // reference model: what the fetch stream should look like
    typedef struct {
        logic [31:0] d;
        logic [31:0] a;
    } ent_t;

    logic [31:0] m_pc;
    logic [31:0] m_kaddr;
    logic [31:0] m_inst;
    logic [31:0] m_iaddr;
    bit          m_started;
    bit          m_discard;
    ent_t        m_held[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_kaddr   = 32'h0;
        m_inst    = NOP;
        m_iaddr   = 32'h0;
        m_started = 1'b0;
        m_discard = 1'b0;
        m_held.delete();
    endtask

    task automatic model_edge(input bit req, input bit ack);
        bit   xfer;
        ent_t e;
        xfer = req && ack;
        if (rst) begin
            model_reset();
        end else if (jump_flag_i) begin
            if (req && !xfer) begin
                if (!m_discard) m_kaddr = m_pc;
                m_discard = 1'b1;
            end else begin
                m_discard = 1'b0;
            end
            m_pc      = jump_addr_i & ~32'h3;
            m_inst    = NOP;
            m_started = 1'b1;
            m_held.delete();
        end else if (!m_started) begin
            m_started = !hold_en;
        end else if (m_held.size() != 0) begin
            if (!hold_en) begin
                e       = m_held.pop_front();
                m_inst  = e.d;
                m_iaddr = e.a;
            end
        end else if (m_discard) begin
            if (xfer) m_discard = 1'b0;
        end else if (xfer) begin
            if (hold_en) begin
                e.d = memf(m_pc);
                e.a = m_pc;
                m_held.push_back(e);
            end else begin
                m_inst  = memf(m_pc);
                m_iaddr = m_pc;
            end
            m_pc = m_pc + 32'd4;
        end else if (!hold_en) begin
            m_inst = NOP;
        end
    endtask

    // one clock: compare at negedge, answer the bus, advance the model, return #1 after posedge
    task automatic step();
        bit          exp_req;
        bit          req_s;
        logic [31:0] exp_addr;
        int          lat;
        @(negedge clk);
        exp_req  = m_started && (m_held.size() == 0);
        exp_addr = m_discard ? m_kaddr : m_pc;
        chk("req", 32'(ibus_req_o), 32'(exp_req));
        if (exp_req) chk("addr", ibus_addr_o, exp_addr);
        chk("inst", inst_o, m_inst);
        chk("inst_addr", inst_addr_o, m_iaddr);
        req_s       = ibus_req_o;
        lat         = lat_rand ? cur_lat : lat_cfg;
        ibus_ack_i  = force_ack || (req_s && wait_cnt >= lat);
        ibus_data_i = ibus_ack_i ? memf(ibus_addr_o) : 32'hDEAD_BEEF;
        model_edge(exp_req, ibus_ack_i);
        @(posedge clk);
        #1;
        if (rst || !req_s || ibus_ack_i) begin
            wait_cnt = 0;
            if (rst || ibus_ack_i) cur_lat = $urandom_range(0, 3);
        end else begin
            wait_cnt++;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        hold_en     = 1'b0;
        jump_flag_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        hold_en     = 1'b0;
        jump_flag_i = 1'b0;
        jump_addr_i = 32'h0;
        ibus_ack_i  = 1'b0;
        ibus_data_i = 32'h0;
        @(posedge clk);
        #1;
        model_reset();

        // zero-wait memory: two bubbles then one instruction per cycle
        lat_cfg = 0;
        do_reset();
        chk("rst_req", 32'(ibus_req_o), 32'h0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_iaddr", inst_addr_o, 32'h0);
        step();
        chk("zw_bubble", inst_o, NOP);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("zw_inst", inst_o, 32'h100 + 32'(i * 4));
            chk("zw_iaddr", inst_addr_o, 32'(i * 4));
        end

        // two wait states
        lat_cfg = 2;
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("ws_addr_hold", ibus_addr_o, 32'h0);
            if (i < 2) step();
        end
        chk("ws_bubble", inst_o, NOP);
        step();
        chk("ws_inst0", inst_o, 32'h100);
        chk("ws_addr_next", ibus_addr_o, 32'h4);
        step();
        chk("ws_nop1", inst_o, NOP);
        step();
        chk("ws_nop2", inst_o, NOP);
        step();
        chk("ws_inst1", inst_o, 32'h104);

        // hold arrives with the ack for 0x8
        lat_cfg = 0;
        do_reset();
        step();
        step();
        step();
        hold_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_req", 32'(ibus_req_o), 32'h0);
            chk("hold_inst", inst_o, 32'h104);
            chk("hold_iaddr", inst_addr_o, 32'h4);
        end
        hold_en = 1'b0;
        step();
        chk("rel_inst", inst_o, 32'h108);
        chk("rel_iaddr", inst_addr_o, 32'h8);
        chk("rel_addr", ibus_addr_o, 32'hC);
        step();
        chk("rel_next", inst_o, 32'h10C);

        // jump while the request to 0x10 is waiting
        lat_cfg = 0;
        do_reset();
        step();
        repeat (4) step();
        lat_cfg     = 3;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0203;
        step();
        jump_flag_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("kill_addr", ibus_addr_o, 32'h10);
            chk("kill_inst", inst_o, NOP);
            step();
        end
        chk("kill_newaddr", ibus_addr_o, 32'h200);
        chk("kill_dropped", inst_o, NOP);
        lat_cfg = 0;
        step();
        chk("jmp_inst", inst_o, 32'h300);
        chk("jmp_iaddr", inst_addr_o, 32'h200);

        // jump and hold together while a word is buffered
        do_reset();
        step();
        step();
        hold_en = 1'b1;
        step();
        chk("full_req", 32'(ibus_req_o), 32'h0);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0400;
        step();
        jump_flag_i = 1'b0;
        chk("fj_inst", inst_o, NOP);
        chk("fj_addr", ibus_addr_o, 32'h400);
        step();
        chk("fj_hold", inst_o, NOP);
        hold_en = 1'b0;
        step();
        chk("fj_inst_tgt", inst_o, 32'h500);
        chk("fj_iaddr_tgt", inst_addr_o, 32'h400);

        // reset in the middle of a wait, then a stray ack
        lat_cfg = 5;
        do_reset();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_req", 32'(ibus_req_o), 32'h0);
        chk("mr_inst", inst_o, NOP);
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        chk("mr_late_ack", inst_o, NOP);
        chk("mr_addr", ibus_addr_o, 32'h0);
        lat_cfg = 0;
        step();
        chk("mr_inst0", inst_o, 32'h100);

        // PC wrap
        do_reset();
        step();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'hFFFF_FFFE;
        step();
        jump_flag_i = 1'b0;
        chk("wrap_addr", ibus_addr_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_inst", inst_o, 32'h0000_00FC);
        chk("wrap_next", ibus_addr_o, 32'h0);

        // random traffic
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            hold_en     = ($urandom_range(0, 9) < 3);
            jump_flag_i = ($urandom_range(0, 11) == 0);
            jump_addr_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom();
            step();
        end
        rst         = 1'b0;
        hold_en     = 1'b0;
        jump_flag_i = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
